// File: rtl/machine_trap_ctrl.sv
// Machine-mode trap controller and sparse CSR bank: run/trap/flush sequencing, interrupt priority, handler redirect.
// Define TRAP_VECTORED_EN to make mtvec[0] writable and enable vectored handler addresses.
module machine_trap_ctrl #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4,
    parameter int DEBUG   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_program,
    input  logic               reset_request,
    input  logic               all_ready,
    input  logic               end_condition,
    input  logic               timer_timeout,
    input  logic [NUM_IRQ-1:0] irq_lines_i,
    input  logic               ready_for_irq_handler,
    input  logic               mret_inst,
    input  logic [XLEN-1:0]    pc_stage_2,
    input  logic [XLEN-1:0]    nextPC_o,
    input  logic               change_PC_condition_for_jump_or_branch,
    input  logic               write_csr,
    input  logic [11:0]        csrReg_write_dest_reg,
    input  logic [XLEN-1:0]    csrReg_write_dest_reg_data,
    input  logic [11:0]        csrReg_read_src_reg,
    output logic [XLEN-1:0]    csrReg_read_src_reg_data,
    output logic               enable_design,
    output logic               irq_prep,
    output logic               flush_o,
    output logic               program_finished,
    output logic [XLEN-1:0]    trap_pc_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic [2:0]         state_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PROGRAM     = 3'd1,
        PARTIAL_IRQ = 3'd2,
        IRQ_HANDLE  = 3'd3,
        FLUSH       = 3'd4,
        DONE        = 3'd5
    } state_t;

    state_t             state;
    logic               mstatus_mie;
    logic               mstatus_mpie;
    logic               mie_mtie;
    logic [NUM_IRQ-1:0] mie_irq;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mepc;
    logic [XLEN-1:0]    mcause;
    logic [4:0]         cause_q;

    logic [XLEN-1:0]    mip_vec;
    logic [XLEN-1:0]    mie_vec;
    logic [XLEN-1:0]    mstatus_vec;
    logic [XLEN-1:0]    pend;
    logic [XLEN-1:0]    mepc_next;
    logic [XLEN-1:0]    trap_base;
    logic [4:0]         win_cause;
    logic               trap_req;

    always_comb begin
        mip_vec                  = '0;
        mip_vec[7]               = timer_timeout;
        mip_vec[16 +: NUM_IRQ]   = irq_lines_i;
        mie_vec                  = '0;
        mie_vec[7]               = mie_mtie;
        mie_vec[16 +: NUM_IRQ]   = mie_irq;
        mstatus_vec              = '0;
        mstatus_vec[3]           = mstatus_mie;
        mstatus_vec[7]           = mstatus_mpie;
        pend                     = mip_vec & mie_vec;
        trap_req                 = mstatus_mie & (|pend);
        // Scan downward so the lowest-index local line is the final winner; MTI is the fallback.
        win_cause = 5'd7;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[16+i]) win_cause = 5'(16 + i);
        end
    end

    assign mepc_next = change_PC_condition_for_jump_or_branch ? nextPC_o : pc_stage_2 + XLEN'(4);

    always_comb begin
        csrReg_read_src_reg_data = '0;
        case (csrReg_read_src_reg)
            ADDR_MSTATUS: csrReg_read_src_reg_data = mstatus_vec;
            ADDR_MIE:     csrReg_read_src_reg_data = mie_vec;
            ADDR_MTVEC:   csrReg_read_src_reg_data = mtvec;
            ADDR_MEPC:    csrReg_read_src_reg_data = mepc;
            ADDR_MCAUSE:  csrReg_read_src_reg_data = mcause;
            ADDR_MIP:     csrReg_read_src_reg_data = mip_vec;
            default:      csrReg_read_src_reg_data = '0;
        endcase
        if (write_csr && csrReg_write_dest_reg == csrReg_read_src_reg) begin
            case (csrReg_read_src_reg)
                ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MEPC, ADDR_MCAUSE:
                    csrReg_read_src_reg_data = csrReg_write_dest_reg_data;
                default: ;
            endcase
        end
    end

    // Software writes come first so same-cycle hardware trap/MRET updates take precedence.
    always_ff @(posedge clk) begin
        if (reset || state == FLUSH) begin
            state        <= (reset || all_ready) ? IDLE : FLUSH;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_irq      <= '0;
            mtvec        <= '0;
            mepc         <= '0;
            mcause       <= '0;
            cause_q      <= '0;
        end else begin
            if (write_csr) begin
                case (csrReg_write_dest_reg)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= csrReg_write_dest_reg_data[3];
                        mstatus_mpie <= csrReg_write_dest_reg_data[7];
                    end
                    ADDR_MIE: begin
                        mie_mtie <= csrReg_write_dest_reg_data[7];
                        mie_irq  <= csrReg_write_dest_reg_data[16 +: NUM_IRQ];
                    end
                    ADDR_MTVEC: begin
`ifdef TRAP_VECTORED_EN
                        mtvec <= {csrReg_write_dest_reg_data[XLEN-1:2], 1'b0,
                                  (csrReg_write_dest_reg_data[1:0] == 2'b01)};
`else
                        mtvec <= {csrReg_write_dest_reg_data[XLEN-1:2], 2'b00};
`endif
                    end
                    ADDR_MEPC:   mepc   <= csrReg_write_dest_reg_data & ~XLEN'(3);
                    ADDR_MCAUSE: mcause <= csrReg_write_dest_reg_data;
                    default: ;
                endcase
            end

            case (state)
                IDLE: if (start_program) state <= PROGRAM;
                PROGRAM: begin
                    if (reset_request) begin
                        state <= FLUSH;
                    end else if (trap_req) begin
                        state   <= PARTIAL_IRQ;
                        cause_q <= win_cause;
                    end else if (end_condition) begin
                        state <= DONE;
                    end
                end
                PARTIAL_IRQ: begin
                    if (reset_request) begin
                        state <= FLUSH;
                    end else if (ready_for_irq_handler) begin
                        mepc         <= mepc_next & ~XLEN'(3);
                        mcause       <= {1'b1, {(XLEN-6){1'b0}}, cause_q};
                        mstatus_mpie <= mstatus_mie;
                        mstatus_mie  <= 1'b0;
                        state        <= IRQ_HANDLE;
                    end
                end
                IRQ_HANDLE: begin
                    if (reset_request) begin
                        state <= FLUSH;
                    end else if (mret_inst) begin
                        mstatus_mie  <= mstatus_mpie;
                        mstatus_mpie <= 1'b1;
                        state        <= PROGRAM;
                    end
                end
                DONE: if (reset_request) state <= FLUSH;
                default: state <= IDLE;
            endcase
        end
    end

    assign trap_base = {mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign trap_pc_o = mtvec[0] ? trap_base + (XLEN'(cause_q) << 2) : trap_base;
`else
    assign trap_pc_o = trap_base;
`endif

    assign mepc_o           = mepc;
    assign state_o          = state;
    assign enable_design    = (state != IDLE);
    assign irq_prep         = (state == PARTIAL_IRQ);
    assign flush_o          = (state == FLUSH);
    assign program_finished = (state == DONE);

    generate
        if (DEBUG != 0) begin : g_debug
            always @(negedge clk) begin
                $write("mstatus=%h mie=%h mtvec=%h mepc=%h mcause=%h mip=%h\n",
                       mstatus_vec, mie_vec, mtvec, mepc, mcause, mip_vec);
            end
        end
    endgenerate

endmodule

// File: tb/tb_machine_trap_ctrl.sv
// Directed bench for machine_trap_ctrl: reset, trap entry/exit, priority, branch mepc, flush and DONE.
module tb_machine_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_program;
    logic        reset_request;
    logic        all_ready;
    logic        end_condition;
    logic        timer_timeout;
    logic [3:0]  irq_lines_i;
    logic        ready_for_irq_handler;
    logic        mret_inst;
    logic [31:0] pc_stage_2;
    logic [31:0] nextPC_o;
    logic        change_PC_condition_for_jump_or_branch;
    logic        write_csr;
    logic [11:0] csrReg_write_dest_reg;
    logic [31:0] csrReg_write_dest_reg_data;
    logic [11:0] csrReg_read_src_reg;
    logic [31:0] csrReg_read_src_reg_data;
    logic        enable_design;
    logic        irq_prep;
    logic        flush_o;
    logic        program_finished;
    logic [31:0] trap_pc_o;
    logic [31:0] mepc_o;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    machine_trap_ctrl dut (
        .clk(clk),
        .reset(reset),
        .start_program(start_program),
        .reset_request(reset_request),
        .all_ready(all_ready),
        .end_condition(end_condition),
        .timer_timeout(timer_timeout),
        .irq_lines_i(irq_lines_i),
        .ready_for_irq_handler(ready_for_irq_handler),
        .mret_inst(mret_inst),
        .pc_stage_2(pc_stage_2),
        .nextPC_o(nextPC_o),
        .change_PC_condition_for_jump_or_branch(change_PC_condition_for_jump_or_branch),
        .write_csr(write_csr),
        .csrReg_write_dest_reg(csrReg_write_dest_reg),
        .csrReg_write_dest_reg_data(csrReg_write_dest_reg_data),
        .csrReg_read_src_reg(csrReg_read_src_reg),
        .csrReg_read_src_reg_data(csrReg_read_src_reg_data),
        .enable_design(enable_design),
        .irq_prep(irq_prep),
        .flush_o(flush_o),
        .program_finished(program_finished),
        .trap_pc_o(trap_pc_o),
        .mepc_o(mepc_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic readCheck(input string tag, input logic [11:0] addr, input logic [31:0] expected);
        csrReg_read_src_reg = addr;
        #1;
        checkOutput(tag, csrReg_read_src_reg_data, expected);
    endtask

    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
        write_csr                  = 1'b1;
        csrReg_write_dest_reg      = addr;
        csrReg_write_dest_reg_data = data;
        tick();
        write_csr                  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_program = 0; reset_request = 0; all_ready = 0; end_condition = 0;
        timer_timeout = 0; irq_lines_i = '0; ready_for_irq_handler = 0; mret_inst = 0;
        pc_stage_2 = '0; nextPC_o = '0; change_PC_condition_for_jump_or_branch = 0;
        write_csr = 0; csrReg_write_dest_reg = '0; csrReg_write_dest_reg_data = '0;
        csrReg_read_src_reg = 12'h344;
        tick(); tick();
        reset = 1'b0;

        checkOutput("reset_state", 32'(state_o), 32'd0);
        checkOutput("reset_enable", 32'(enable_design), 32'd0);
        checkOutput("reset_outputs", {28'd0, irq_prep, flush_o, program_finished, 1'b0}, 32'd0);
        checkOutput("reset_trap_pc", trap_pc_o, 32'd0);
        checkOutput("reset_mepc", mepc_o, 32'd0);
        readCheck("reset_rdata", 12'h344, 32'd0);

        start_program = 1'b1; tick(); start_program = 1'b0;
        checkOutput("start_state", 32'(state_o), 32'd1);
        checkOutput("start_enable", 32'(enable_design), 32'd1);
        readCheck("start_mstatus", 12'h300, 32'd0);
        readCheck("start_mtvec", 12'h305, 32'd0);
        readCheck("start_mepc", 12'h341, 32'd0);

        applyStimulus(12'h305, 32'h0000_0100);
        applyStimulus(12'h300, 32'h0000_0008);
        applyStimulus(12'h304, 32'h0000_0080);
        applyStimulus(12'h344, 32'hFFFF_FFFF);
        readCheck("mtvec_rd", 12'h305, 32'h0000_0100);
        readCheck("mstatus_rd", 12'h300, 32'h0000_0008);
        readCheck("mie_rd", 12'h304, 32'h0000_0080);
        readCheck("mip_write_ignored", 12'h344, 32'd0);

        write_csr = 1'b1; csrReg_write_dest_reg = 12'h342; csrReg_write_dest_reg_data = 32'h0000_1234;
        readCheck("forward_mcause", 12'h342, 32'h0000_1234);
        tick(); write_csr = 1'b0;

        // Timer trap with direct mtvec; software mepc write collides with trap entry.
        pc_stage_2 = 32'h40; ready_for_irq_handler = 1'b1; timer_timeout = 1'b1;
        tick();
        checkOutput("trap_partial_state", 32'(state_o), 32'd2);
        checkOutput("trap_irq_prep", 32'(irq_prep), 32'd1);
        checkOutput("trap_pc_direct", trap_pc_o, 32'h0000_0100);
        readCheck("mip_timer", 12'h344, 32'h0000_0080);
        write_csr = 1'b1; csrReg_write_dest_reg = 12'h341; csrReg_write_dest_reg_data = 32'h999;
        tick(); write_csr = 1'b0;
        checkOutput("handle_state", 32'(state_o), 32'd3);
        checkOutput("handle_mepc", mepc_o, 32'h0000_0044);
        readCheck("handle_mcause", 12'h342, 32'h8000_0007);
        readCheck("handle_mstatus", 12'h300, 32'h0000_0080);
        checkOutput("handle_trap_pc", trap_pc_o, 32'h0000_0100);

        timer_timeout = 1'b0; mret_inst = 1'b1; tick(); mret_inst = 1'b0;
        checkOutput("mret_state", 32'(state_o), 32'd1);
        readCheck("mret_mstatus", 12'h300, 32'h0000_0088);

        // Taken branch in the trap-entry cycle.
        timer_timeout = 1'b1; tick();
        checkOutput("branch_partial", 32'(state_o), 32'd2);
        change_PC_condition_for_jump_or_branch = 1'b1; nextPC_o = 32'h200;
        tick();
        change_PC_condition_for_jump_or_branch = 1'b0; timer_timeout = 1'b0;
        checkOutput("branch_mepc", mepc_o, 32'h0000_0200);
        mret_inst = 1'b1; tick(); mret_inst = 1'b0;
        checkOutput("branch_mret_state", 32'(state_o), 32'd1);

        // Line 2 and timer together; sources drop before the handler is ready.
        ready_for_irq_handler = 1'b0; pc_stage_2 = 32'h80;
        applyStimulus(12'h305, 32'h0000_0101);
        applyStimulus(12'h304, 32'h0004_0080);
        irq_lines_i = 4'b0100; timer_timeout = 1'b1;
        tick();
        irq_lines_i = '0; timer_timeout = 1'b0;
        tick();
        checkOutput("prio_held_state", 32'(state_o), 32'd2);
        checkOutput("prio_mepc_unchanged", mepc_o, 32'h0000_0200);
`ifdef TRAP_VECTORED_EN
        readCheck("prio_mtvec", 12'h305, 32'h0000_0101);
        checkOutput("prio_trap_pc", trap_pc_o, 32'h0000_0148);
`else
        readCheck("prio_mtvec", 12'h305, 32'h0000_0100);
        checkOutput("prio_trap_pc", trap_pc_o, 32'h0000_0100);
`endif
        ready_for_irq_handler = 1'b1; tick(); ready_for_irq_handler = 1'b0;
        checkOutput("prio_state", 32'(state_o), 32'd3);
        readCheck("prio_mcause", 12'h342, 32'h8000_0012);
        checkOutput("prio_mepc", mepc_o, 32'h0000_0084);

        // Flush out of the handler, then everything clears.
        reset_request = 1'b1; tick(); reset_request = 1'b0;
        checkOutput("flush_state", 32'(state_o), 32'd4);
        checkOutput("flush_o", 32'(flush_o), 32'd1);
        checkOutput("flush_enable", 32'(enable_design), 32'd1);
        all_ready = 1'b1; tick(); all_ready = 1'b0;
        checkOutput("idle_state", 32'(state_o), 32'd0);
        checkOutput("idle_enable", 32'(enable_design), 32'd0);
        checkOutput("idle_mepc_o", mepc_o, 32'd0);
        checkOutput("idle_trap_pc", trap_pc_o, 32'd0);
        readCheck("idle_mstatus", 12'h300, 32'd0);
        readCheck("idle_mtvec", 12'h305, 32'd0);
        readCheck("idle_mcause", 12'h342, 32'd0);
        readCheck("idle_mie", 12'h304, 32'd0);

        start_program = 1'b1; tick(); start_program = 1'b0;
        end_condition = 1'b1; tick(); end_condition = 1'b0;
        checkOutput("done_state", 32'(state_o), 32'd5);
        checkOutput("done_finished", 32'(program_finished), 32'd1);
        reset_request = 1'b1; tick(); reset_request = 1'b0;
        checkOutput("done_flush", 32'(state_o), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
